icb_slave_stim_gen: RTL and testbench

- Parametrised, synthesisable ICB slave responder for the e203 core bench; replaces per-port constant/random tie-offs on the core's ICB slave-side inputs (ppi, clint, plic, fio, mem, lsu2itcm, lsu2dtcm).
- Accepts commands with configurable or pseudo-random back-pressure.
- Queues up to OUTS_DEPTH outstanding transactions and returns in-order responses after a programmable latency.
- Response data is a deterministic function of the address, so a scoreboard can predict it.

---
 rtl/icb_slave_stim_gen_if.sv | 26 ++
 rtl/icb_slave_stim_gen.sv | 117 +++++++++++
 tb/tb_icb_slave_stim_gen.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icb_slave_stim_gen_if.sv
// ICB command/response bundle between a bus master and the stimulus slave.
interface icb_slave_stim_gen_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) ();
   logic          icb_cmd_valid;
   logic          icb_cmd_ready;
   logic [AW-1:0] icb_cmd_addr;
   logic          icb_cmd_read;
   logic          icb_cmd_excl;
   logic          icb_rsp_valid;
   logic          icb_rsp_ready;
   logic          icb_rsp_err;
   logic          icb_rsp_excl_ok;
   logic [DW-1:0] icb_rsp_rdata;

   modport master (
      output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_excl, icb_rsp_ready,
      input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_excl_ok, icb_rsp_rdata
   );

   modport slave (
      input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_excl, icb_rsp_ready,
      output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_excl_ok, icb_rsp_rdata
   );
endinterface

// File: rtl/icb_slave_stim_gen.sv
// ICB slave responder: queued in-order responses after cfg_lat, optional LFSR back-pressure.
// Define ICB_STIM_ERR_INJ_EN to add address-matched error injection (cfg_err_base/cfg_err_mask).
module icb_slave_stim_gen #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned OUTS_DEPTH = 4,
   parameter int unsigned LAT_W      = 4,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter logic [31:0] DATA_SEED  = 32'h5A5A_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [LAT_W-1:0]     cfg_lat,
   input  logic                 cfg_rand_bp,
`ifdef ICB_STIM_ERR_INJ_EN
   input  logic [AW-1:0]        cfg_err_base,
   input  logic [AW-1:0]        cfg_err_mask,
`endif
   icb_slave_stim_gen_if.slave  icb,
   output logic [15:0]          cmd_cnt,
   output logic [15:0]          rsp_cnt
);
   localparam int unsigned IW  = $clog2(OUTS_DEPTH);
   localparam int unsigned PW  = IW + 1;
   localparam int unsigned REP = (DW + 31) / 32;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          read;
      logic          excl;
      logic          err;
   } entry_t;

   entry_t            mem_q [OUTS_DEPTH];
   entry_t            mem_d [OUTS_DEPTH];
   logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LAT_W-1:0]  cnt_q, cnt_d;
   logic              hold_q, hold_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [15:0]       cmd_cnt_q, cmd_cnt_d, rsp_cnt_q, rsp_cnt_d;

   logic              empty, full, bp_ok, push, pop, rsp_valid;
   entry_t            head, new_ent;
   logic [31:0]       rd_word;
   logic [REP*32-1:0] rd_rep;

   always_comb begin
      empty     = (wptr_q == rptr_q);
      full      = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[IW-1:0] == rptr_q[IW-1:0]);
      bp_ok     = !cfg_rand_bp || (lfsr_q[1:0] != 2'b00);
      head      = mem_q[rptr_q[IW-1:0]];
      // hold_q keeps a presented response up even if cfg_lat is raised underneath it
      rsp_valid = !empty && (hold_q || (cnt_q >= cfg_lat));

      icb.icb_cmd_ready = rst_n && !full && bp_ok;
      push = icb.icb_cmd_valid && icb.icb_cmd_ready;
      pop  = rsp_valid && icb.icb_rsp_ready;

      new_ent.addr = icb.icb_cmd_addr;
      new_ent.read = icb.icb_cmd_read;
      new_ent.excl = icb.icb_cmd_excl;
`ifdef ICB_STIM_ERR_INJ_EN
      new_ent.err  = ((icb.icb_cmd_addr & cfg_err_mask) == (cfg_err_base & cfg_err_mask));
`else
      new_ent.err  = 1'b0;
`endif

      rd_word = 32'(head.addr) ^ DATA_SEED;
      rd_rep  = {REP{rd_word}};

      icb.icb_rsp_valid   = rsp_valid;
      icb.icb_rsp_err     = rsp_valid && head.err;
      icb.icb_rsp_excl_ok = rsp_valid && head.excl && head.read && !head.err;
      icb.icb_rsp_rdata   = (rsp_valid && head.read && !head.err) ? rd_rep[DW-1:0] : '0;

      cmd_cnt = cmd_cnt_q;
      rsp_cnt = rsp_cnt_q;
   end

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wptr_q[IW-1:0]] = new_ent;
      wptr_d = wptr_q + (push ? PW'(1) : '0);
      rptr_d = rptr_q + (pop  ? PW'(1) : '0);

      cnt_d = cnt_q;
      if (pop)                             cnt_d = '0;
      else if (!empty && (cnt_q < cfg_lat)) cnt_d = cnt_q + LAT_W'(1);

      hold_d    = rsp_valid && !icb.icb_rsp_ready;
      lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      cmd_cnt_d = cmd_cnt_q + (push ? 16'd1 : 16'd0);
      rsp_cnt_d = rsp_cnt_q + (pop  ? 16'd1 : 16'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q     <= '{default: '0};
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         hold_q    <= 1'b0;
         lfsr_q    <= LFSR_SEED;
         cmd_cnt_q <= '0;
         rsp_cnt_q <= '0;
      end else begin
         mem_q     <= mem_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         lfsr_q    <= lfsr_d;
         cmd_cnt_q <= cmd_cnt_d;
         rsp_cnt_q <= rsp_cnt_d;
      end
   end
endmodule

// File: tb/tb_icb_slave_stim_gen.sv
// Bench for icb_slave_stim_gen: directed and random traffic against a timing/queue reference model.
module tb_icb_slave_stim_gen;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  cfg_lat;
   logic        cfg_rand_bp;
   logic [15:0] cmd_cnt, rsp_cnt;
`ifdef ICB_STIM_ERR_INJ_EN
   logic [31:0] cfg_err_base, cfg_err_mask;
`endif

   icb_slave_stim_gen_if #(.AW(32), .DW(32)) bus ();

   icb_slave_stim_gen #(
      .AW(32), .DW(32), .OUTS_DEPTH(DEPTH), .LAT_W(4),
      .LFSR_SEED(16'hACE1), .DATA_SEED(32'h5A5A_0000)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cfg_lat(cfg_lat),
      .cfg_rand_bp(cfg_rand_bp),
`ifdef ICB_STIM_ERR_INJ_EN
      .cfg_err_base(cfg_err_base),
      .cfg_err_mask(cfg_err_mask),
`endif
      .icb(bus),
      .cmd_cnt(cmd_cnt),
      .rsp_cnt(rsp_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        read;
      logic        excl;
      logic        err;
      int          acc;
   } ent_t;

   ent_t        q[$];
   int          ncyc;
   int          last_pop;
   logic        held;
   logic [15:0] lfsr;
   logic [15:0] cmd_n, rsp_n;
   int          checks = 0;
   int          failures = 0;
   int          lo_cnt;
   int          occ_max;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic [15:0] b;
      b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'd1;
      return (s >> 1) | (b << 15);
   endfunction

   function automatic logic is_err(input logic [31:0] a);
`ifdef ICB_STIM_ERR_INJ_EN
      return (a & cfg_err_mask) == (cfg_err_base & cfg_err_mask);
`else
      return (a == a) ? 1'b0 : 1'b1;
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      last_pop = -1000;
      held     = 1'b0;
      lfsr     = 16'hACE1;
      cmd_n    = '0;
      rsp_n    = '0;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic rd, input logic ex);
      bus.icb_cmd_valid = v;
      bus.icb_cmd_addr  = a;
      bus.icb_cmd_read  = rd;
      bus.icb_cmd_excl  = ex;
   endtask

   // One clock: check outputs at negedge against the model, then advance the model.
   task automatic step();
      logic        exp_rdy, exp_vld, exp_err, exp_xok, push, pop;
      logic [31:0] exp_rd;
      int          elig;
      ent_t        e;
      @(negedge clk);
      exp_rdy = (q.size() < DEPTH) && (!cfg_rand_bp || (lfsr[1:0] != 2'b00));
      exp_vld = 1'b0; exp_err = 1'b0; exp_xok = 1'b0; exp_rd = '0;
      if (q.size() > 0) begin
         elig    = (q[0].acc > last_pop) ? q[0].acc + 1 : last_pop + 1;
         exp_vld = held || (ncyc >= elig + int'(cfg_lat));
         if (exp_vld) begin
            exp_err = q[0].err;
            exp_xok = q[0].read && q[0].excl && !q[0].err;
            exp_rd  = (q[0].read && !q[0].err) ? (q[0].addr ^ 32'h5A5A_0000) : 32'h0;
         end
      end
      chk("cmd_ready", 64'(bus.icb_cmd_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(bus.icb_rsp_valid), 64'(exp_vld));
      chk("rsp_err", 64'(bus.icb_rsp_err), 64'(exp_err));
      chk("rsp_excl_ok", 64'(bus.icb_rsp_excl_ok), 64'(exp_xok));
      chk("rsp_rdata", 64'(bus.icb_rsp_rdata), 64'(exp_rd));
      chk("cmd_cnt", 64'(cmd_cnt), 64'(cmd_n));
      chk("rsp_cnt", 64'(rsp_cnt), 64'(rsp_n));
      if (!bus.icb_cmd_ready) lo_cnt++;
      if (int'(cmd_cnt - rsp_cnt) > occ_max) occ_max = int'(cmd_cnt - rsp_cnt);
      push = exp_rdy && bus.icb_cmd_valid;
      pop  = exp_vld && bus.icb_rsp_ready;
      if (pop) begin
         void'(q.pop_front());
         last_pop = ncyc;
         rsp_n++;
      end
      held = exp_vld && !pop;
      if (push) begin
         e.addr = bus.icb_cmd_addr; e.read = bus.icb_cmd_read; e.excl = bus.icb_cmd_excl;
         e.err  = is_err(bus.icb_cmd_addr); e.acc = ncyc;
         q.push_back(e);
         cmd_n++;
      end
      lfsr = lfsr_next(lfsr);
      ncyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_cmd_ready"}, 64'(bus.icb_cmd_ready), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(bus.icb_rsp_valid), 64'd0);
      chk({tag, "_rsp_err"}, 64'(bus.icb_rsp_err), 64'd0);
      chk({tag, "_excl_ok"}, 64'(bus.icb_rsp_excl_ok), 64'd0);
      chk({tag, "_rdata"}, 64'(bus.icb_rsp_rdata), 64'd0);
      chk({tag, "_cmd_cnt"}, 64'(cmd_cnt), 64'd0);
      chk({tag, "_rsp_cnt"}, 64'(rsp_cnt), 64'd0);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && q.size() > 0; i++) step();
      chk({tag, "_drain_left"}, 64'(q.size()), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      ncyc = 0; lo_cnt = 0; occ_max = 0;
      rst_n = 1'b0; cfg_lat = '0; cfg_rand_bp = 1'b0;
`ifdef ICB_STIM_ERR_INJ_EN
      cfg_err_base = 32'h4000; cfg_err_mask = 32'hF000;
`endif
      drive(1'b0, '0, 1'b0, 1'b0);
      bus.icb_rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("por");
      rst_n = 1'b1;
      model_reset();

      // single read, latency 0
      bus.icb_rsp_ready = 1'b1;
      drive(1'b1, 32'h0000_1000, 1'b1, 1'b0);
      step();
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("t1_rsp_valid", 64'(bus.icb_rsp_valid), 64'd1);
      chk("t1_rdata", 64'(bus.icb_rsp_rdata), 64'h5A5A_1000);
      step();
      chk("t1_cmd_cnt", 64'(cmd_cnt), 64'd1);
      chk("t1_rsp_cnt", 64'(rsp_cnt), 64'd1);
      step();

      // fill to capacity under latency 3, then drain in order
      cfg_lat = 4'd3; bus.icb_rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
         step();
      end
      chk("t2_ready_full", 64'(bus.icb_cmd_ready), 64'd0);
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (3) step();
      bus.icb_rsp_ready = 1'b1;
      drain("t2");
      step();

      // exclusive write vs exclusive read
      cfg_lat = 4'd1;
      drive(1'b1, 32'h20, 1'b0, 1'b1); step();
      drive(1'b1, 32'h20, 1'b1, 1'b1); step();
      drive(1'b0, '0, 1'b0, 1'b0);
      drain("t3");

      // hold response under back-pressure while cfg_lat toggles
      cfg_lat = 4'd2; bus.icb_rsp_ready = 1'b0;
      drive(1'b1, 32'h0000_0ABC, 1'b1, 1'b1); step();
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (3) step();
      for (int i = 0; i < 6; i++) begin
         cfg_lat = (i % 2 == 0) ? 4'd15 : 4'd0;
         step();
         chk("t4_hold_rdata", 64'(bus.icb_rsp_rdata), 64'h5A5A_0ABC);
      end
      cfg_lat = 4'd0; bus.icb_rsp_ready = 1'b1;
      drain("t4");

      // random back-pressure, streaming commands
      cfg_rand_bp = 1'b1; lo_cnt = 0; occ_max = 0;
      for (int i = 0; i < 200; i++) begin
         drive(1'b1, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         step();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("t5_bp_rate", 64'((lo_cnt >= 25) && (lo_cnt <= 80)), 64'd1);
      chk("t5_occ_max", 64'(occ_max <= DEPTH), 64'd1);
      drain("t5");
      cfg_rand_bp = 1'b0;

      // random valid/ready traffic with latency 2
      cfg_lat = 4'd2;
      for (int i = 0; i < 150; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom & 32'h0000_FFFF, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         bus.icb_rsp_ready = 1'($urandom_range(0, 1));
         step();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      bus.icb_rsp_ready = 1'b1;
      drain("t6");

      // reset with pending entries
      cfg_lat = 4'd5; bus.icb_rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h300 + 32'(i * 4), 1'b1, 1'b0);
         step();
      end
      rst_n = 1'b0;
      #1;
      chk_zero("mid_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      drive(1'b0, '0, 1'b0, 1'b0);
      bus.icb_rsp_ready = 1'b1;
      repeat (10) step();
      chk("t7_cmd_cnt", 64'(cmd_cnt), 64'd0);

`ifdef ICB_STIM_ERR_INJ_EN
      cfg_lat = 4'd0;
      drive(1'b1, 32'h4010, 1'b1, 1'b1); step();
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("t8_err", 64'(bus.icb_rsp_err), 64'd1);
      chk("t8_rdata", 64'(bus.icb_rsp_rdata), 64'd0);
      drain("t8");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
